// File: rtl/debug_monitor_mem_ctrl.sv
// debug_monitor_mem_ctrl: system-clock executor for the debug slave's monitor
// memory commands. It loads the address, reads and writes the OCI debug RAM,
// and reports MonDReg, monitor_ready and monitor_error.
// Optional feature: define MONITOR_TIMEOUT_EN to build the stall timeout
// counter and its abort path. Without it, accesses wait on mem_waitrequest
// indefinitely and monitor_error is tied to 0.
module debug_monitor_mem_ctrl #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADDEAD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_waitrequest
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state;

  logic start_rd;
  logic start_wr;
  logic unused_bits;

`ifdef MONITOR_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] stall_cnt;
  assign unused_bits = ^{jdo[37:35], jdo[2:0]};
`else
  assign monitor_error = 1'b0;
  assign unused_bits = ^{jdo[37:35], jdo[2:0], ERR_DATA, TIMEOUT};
`endif

  // Decode the accepted access from prioritised command pulses (IDLE only).
  always_comb begin
    start_rd = 1'b0;
    start_wr = 1'b0;
    if (state == IDLE) begin
      if (take_action_ocimem_a)         start_rd = jdo[34];
      else if (take_action_ocimem_b)    start_wr = 1'b1;
      else if (take_no_action_ocimem_a) start_rd = 1'b1;
    end
  end

  // Access FSM with registered strobes, address counter and monitor status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      mem_addr      <= '0;
      mem_rd        <= 1'b0;
      mem_wr        <= 1'b0;
      mem_wdata     <= '0;
`ifdef MONITOR_TIMEOUT_EN
      monitor_error <= 1'b0;
      stall_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (take_action_ocimem_a)
            mem_addr <= jdo[ADDR_W+16:17];
          else if (take_action_ocimem_b)
            mem_wdata <= jdo[34:3];
          if (start_rd || start_wr) begin
            state         <= start_rd ? READ : WRITE;
            mem_rd        <= start_rd;
            mem_wr        <= start_wr;
            monitor_ready <= 1'b0;
`ifdef MONITOR_TIMEOUT_EN
            monitor_error <= 1'b0;
            stall_cnt     <= '0;
`endif
          end
        end
        READ, WRITE: begin
          if (!mem_waitrequest) begin
            if (state == READ) MonDReg <= mem_rdata;
            mem_addr      <= mem_addr + 1'b1;
            mem_rd        <= 1'b0;
            mem_wr        <= 1'b0;
            monitor_ready <= 1'b1;
            state         <= IDLE;
          end
`ifdef MONITOR_TIMEOUT_EN
          // The TIMEOUT-th stall cycle aborts; the address is left in place.
          else if (stall_cnt == CNT_LAST) begin
            MonDReg       <= ERR_DATA;
            monitor_error <= 1'b1;
            mem_rd        <= 1'b0;
            mem_wr        <= 1'b0;
            monitor_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state  <= IDLE;
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_monitor_mem_ctrl.sv
// tb_debug_monitor_mem_ctrl: directed vectors for debug_monitor_mem_ctrl with
// a small RAM model on the memory port. Timeout vectors are built only when
// MONITOR_TIMEOUT_EN is defined.
module tb_debug_monitor_mem_ctrl;

  logic        clk;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_waitrequest;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ram [0:255];
  logic        pl_en   = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  int          wr_done = 0;

  debug_monitor_mem_ctrl #(
    .ADDR_W  (8),
    .TIMEOUT (255),
    .ERR_DATA(32'hDEADDEAD)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_action_ocimem_a),
    .take_action_ocimem_b   (take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error),
    .mem_addr               (mem_addr),
    .mem_rd                 (mem_rd),
    .mem_wr                 (mem_wr),
    .mem_wdata              (mem_wdata),
    .mem_rdata              (mem_rdata),
    .mem_waitrequest        (mem_waitrequest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: preload port for the bench, write port for the DUT.
  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (mem_wr && !mem_waitrequest) begin
      ram[mem_addr] <= mem_wdata;
      wr_done <= wr_done + 1;
    end
  end

  assign mem_rdata = ram[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  function automatic logic [37:0] jdo_addr(input logic [7:0] a, input logic rd);
    logic [37:0] j;
    j = '0;
    j[24:17] = a;
    j[34] = rd;
    return j;
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rd_cycles;
    int wr_base;
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    mem_waitrequest = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_mondreg", MonDReg, 32'h0);
    check("rst_ready", 32'(monitor_ready), 32'd1);
    check("rst_error", 32'(monitor_error), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_rd", 32'(mem_rd), 32'd0);
    check("rst_wr", 32'(mem_wr), 32'd0);
    check("rst_wdata", mem_wdata, 32'h0);

    poke(8'h10, 32'h12345678);
    poke(8'h00, 32'h00C0FFEE);
    poke(8'h01, 32'h11112222);
    poke(8'h20, 32'h20202020);
    reset = 1'b0;
    tick();

    // Address load + read, zero wait states
    jdo = jdo_addr(8'h10, 1'b1); take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    check("ld_rd_strobe", 32'(mem_rd), 32'd1);
    check("ld_rd_addr", 32'(mem_addr), 32'h10);
    check("ld_rd_busy", 32'(monitor_ready), 32'd0);
    tick();
    check("ld_rd_data", MonDReg, 32'h12345678);
    check("ld_rd_ready", 32'(monitor_ready), 32'd1);
    check("ld_rd_strobe_off", 32'(mem_rd), 32'd0);
    check("ld_rd_incr", 32'(mem_addr), 32'h11);

    // Address load without read stays idle
    jdo = jdo_addr(8'hFF, 1'b0); take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    check("ld_only_addr", 32'(mem_addr), 32'hFF);
    check("ld_only_ready", 32'(monitor_ready), 32'd1);
    check("ld_only_rd", 32'(mem_rd), 32'd0);

    // Write at 0xFF, address wraps, then read-next at 0x00
    jdo = jdo_data(32'hCAFEF00D); take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    check("wr_strobe", 32'(mem_wr), 32'd1);
    check("wr_wdata", mem_wdata, 32'hCAFEF00D);
    check("wr_addr", 32'(mem_addr), 32'hFF);
    tick();
    check("wr_done_strobe", 32'(mem_wr), 32'd0);
    check("wr_wrap", 32'(mem_addr), 32'h00);
    check("wr_ready", 32'(monitor_ready), 32'd1);
    check("wr_ram", ram[8'hFF], 32'hCAFEF00D);
    check("wr_mondreg_kept", MonDReg, 32'h12345678);
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    check("rn_strobe", 32'(mem_rd), 32'd1);
    check("rn_addr", 32'(mem_addr), 32'h00);
    tick();
    check("rn_data", MonDReg, 32'h00C0FFEE);
    check("rn_incr", 32'(mem_addr), 32'h01);

    // Read with 5 wait states
    mem_waitrequest = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    rd_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_rd) rd_cycles++;
      tick();
    end
    mem_waitrequest = 1'b0;
    if (mem_rd) rd_cycles++;
    check("ws_data_pending", MonDReg, 32'h00C0FFEE);
    tick();
    check("ws_rd_cycles", 32'(rd_cycles), 32'd6);
    check("ws_data", MonDReg, 32'h11112222);
    check("ws_strobe_off", 32'(mem_rd), 32'd0);
    check("ws_error", 32'(monitor_error), 32'd0);
    check("ws_incr", 32'(mem_addr), 32'h02);

    // Read command during WRITE is dropped
    wr_base = wr_done;
    mem_waitrequest = 1'b1;
    jdo = jdo_data(32'h5555AAAA); take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    check("busy_wr_held", 32'(mem_wr), 32'd1);
    check("busy_no_rd", 32'(mem_rd), 32'd0);
    check("busy_addr", 32'(mem_addr), 32'h02);
    mem_waitrequest = 1'b0;
    tick();
    check("busy_wr_off", 32'(mem_wr), 32'd0);
    check("busy_addr_incr", 32'(mem_addr), 32'h03);
    tick(); tick();
    check("busy_one_write", 32'(wr_done - wr_base), 32'd1);
    check("busy_no_rd_after", 32'(mem_rd), 32'd0);
    check("busy_ram", ram[8'h02], 32'h5555AAAA);
    check("busy_mondreg_kept", MonDReg, 32'h11112222);

    // Address load wins over simultaneous write
    wr_base = wr_done;
    jdo = jdo_addr(8'h40, 1'b0);
    take_action_ocimem_a = 1'b1; take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    check("prio_addr", 32'(mem_addr), 32'h40);
    check("prio_no_wr", 32'(mem_wr), 32'd0);
    check("prio_ready", 32'(monitor_ready), 32'd1);
    check("prio_wdata_kept", mem_wdata, 32'h5555AAAA);
    tick();
    check("prio_no_write", 32'(wr_done - wr_base), 32'd0);

`ifdef MONITOR_TIMEOUT_EN
    // Stuck waitrequest aborts after 255 stall cycles
    mem_waitrequest = 1'b1;
    jdo = jdo_addr(8'h20, 1'b1); take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    rd_cycles = 0;
    while (mem_rd && rd_cycles < 300) begin
      rd_cycles++;
      tick();
    end
    check("to_rd_cycles", 32'(rd_cycles), 32'd255);
    check("to_error", 32'(monitor_error), 32'd1);
    check("to_mondreg", MonDReg, 32'hDEADDEAD);
    check("to_addr", 32'(mem_addr), 32'h20);
    check("to_ready", 32'(monitor_ready), 32'd1);
    mem_waitrequest = 1'b0;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    check("to_error_clr", 32'(monitor_error), 32'd0);
    tick();
    check("to_next_data", MonDReg, 32'h20202020);
`endif

    // Reset during a stalled read
    mem_waitrequest = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    tick(); tick();
    check("mr_rd_before", 32'(mem_rd), 32'd1);
    reset = 1'b1;
    #1;
    check("mr_rd", 32'(mem_rd), 32'd0);
    check("mr_mondreg", MonDReg, 32'h0);
    check("mr_ready", 32'(monitor_ready), 32'd1);
    check("mr_addr", 32'(mem_addr), 32'h0);
    tick();
    reset = 1'b0;
    mem_waitrequest = 1'b0;
    tick();
    check("mr_idle", 32'(mem_rd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/debug_monitor_mem_ctrl.md
Name: debug_monitor_mem_ctrl

Overview:
- System-clock-domain consumer of the debug slave's decoded JTAG commands: `jdo`, `take_action_ocimem_a`, `take_action_ocimem_b` and `take_no_action_ocimem_a`.
- Executes the monitor memory reads and writes those commands request against the CPU's on-chip debug RAM.
- Returns `MonDReg`, `monitor_ready` and `monitor_error`, which feed back into the debug slave wrapper inputs of the same names.
- Sits between the debug slave sysclk stage and the OCI debug RAM.

Parameters:
- `ADDR_W`, default 8: word-address width of the debug RAM; the address counter wraps at 2^ADDR_W.
- `TIMEOUT`, default 255: maximum cycles an access may stall on `mem_waitrequest` before it is aborted.
- `ERR_DATA`, default 32'hDEADDEAD: value loaded into `MonDReg` when an access times out.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `jdo`  in  38  JTAG data-out word from the debug slave.
- `take_action_ocimem_a`  in  1  address-load command, one-cycle pulse.
- `take_action_ocimem_b`  in  1  write-and-increment command, one-cycle pulse.
- `take_no_action_ocimem_a`  in  1  read-and-increment command, one-cycle pulse.
- `MonDReg`  out  32  monitor data register (read result).
- `monitor_ready`  out  1  high when idle and the last access has completed.
- `monitor_error`  out  1  sticky flag: the last access timed out.
- `mem_addr`  out  ADDR_W  debug RAM word address.
- `mem_rd`  out  1  read strobe.
- `mem_wr`  out  1  write strobe.
- `mem_wdata`  out  32  write data.
- `mem_rdata`  in  32  read data, valid in the cycle `mem_rd` is high and `mem_waitrequest` is low.
- `mem_waitrequest`  in  1  slave stall.

Behaviour:
- Reset values:
  - `MonDReg`=0, `monitor_ready`=1, `monitor_error`=0.
  - `mem_addr`=0, `mem_rd`=0, `mem_wr`=0, `mem_wdata`=0.
  - FSM in IDLE, timeout counter 0.
  - Reset asserted mid-access aborts the access immediately; no partial write-back to `MonDReg`.
- Command field decode:
  - `take_action_ocimem_a`: `mem_addr` <= `jdo[ADDR_W+16:17]`. If `jdo[34]`=1, a read at the new address is also started.
  - `take_action_ocimem_b`: `mem_wdata` <= `jdo[34:3]`; write at the current `mem_addr` is started.
  - `take_no_action_ocimem_a`: read at the current `mem_addr` is started.
- Commands are accepted only in IDLE. Commands pulsed while in READ or WRITE are dropped; state and outputs are unchanged.
- Simultaneous pulses are prioritised `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`; only one is acted on.
- Accepting any access clears `monitor_error` and drives `monitor_ready` to 0 in the next cycle.
- FSM states: IDLE, READ, WRITE.
- IDLE:
  - An accepted read moves to READ; an accepted write moves to WRITE.
  - An address load with `jdo[34]`=0 stays in IDLE with `monitor_ready` kept at 1.
- READ:
  - `mem_rd`=1.
  - In the cycle `mem_waitrequest`=0: `MonDReg` <= `mem_rdata`, `mem_addr` increments, FSM returns to IDLE.
- WRITE:
  - `mem_wr`=1.
  - In the cycle `mem_waitrequest`=0: `mem_addr` increments, FSM returns to IDLE, `MonDReg` is unchanged.
- On return to IDLE, `mem_rd` and `mem_wr` are 0 and `monitor_ready`=1 in the following cycle.
- Latency:
  - Command pulse at cycle N; strobe asserted at N+1.
  - With zero wait states, `MonDReg` is valid and `monitor_ready`=1 at N+2.
  - Each wait-state cycle adds one cycle.
- Address increment is modulo 2^ADDR_W: all-ones wraps to 0.
- Timeout counter:
  - Counts cycles spent in READ or WRITE with `mem_waitrequest`=1; cleared on entry to either state.
  - When the count reaches `TIMEOUT`, the access aborts: strobes drop, `monitor_error`=1, and `MonDReg` <= `ERR_DATA` (reads and writes alike).
  - `mem_addr` is not incremented on a timeout; FSM returns to IDLE.

Optional Feature:
- `MONITOR_TIMEOUT_EN` defined: the timeout counter and abort path exist exactly as described above.
- `MONITOR_TIMEOUT_EN` undefined:
  - No counter is built.
  - Accesses wait indefinitely on `mem_waitrequest`.
  - `monitor_error` is tied to 0 and `ERR_DATA` is unused.

Test Plan:
- Address load + read: `take_action_ocimem_a` with `jdo[24:17]`=8'h10, `jdo[34]`=1; RAM[0x10]=32'h12345678, no wait states -> `mem_rd` at N+1 with `mem_addr`=0x10; `MonDReg`=32'h12345678 and `monitor_ready`=1 at N+2; `mem_addr`=0x11.
- Write then read-next: address 0xFF; `take_action_ocimem_b` with `jdo[34:3]`=32'hCAFEF00D -> `mem_wr`=1, `mem_wdata`=32'hCAFEF00D, `mem_addr`=0xFF; `mem_addr` wraps to 0x00; a following `take_no_action_ocimem_a` reads address 0x00.
- Wait states: `mem_waitrequest` high for 5 cycles on a read -> `mem_rd` held 6 cycles; `MonDReg` updated one cycle after `mem_waitrequest` falls; `monitor_error`=0.
- Timeout (`MONITOR_TIMEOUT_EN`): `mem_waitrequest` stuck high -> strobe drops after 255 stall cycles; `monitor_error`=1; `MonDReg`=32'hDEADDEAD; `mem_addr` unchanged. The next accepted command clears `monitor_error`.
- Busy drop and priority:
  - Pulse `take_no_action_ocimem_a` while in WRITE -> ignored; exactly one `mem_wr` access occurs.
  - Pulse `take_action_ocimem_a` (`jdo[34]`=0) together with `take_action_ocimem_b` in IDLE -> only the address load occurs; no write.
- Reset mid-read: assert `reset` during a stalled READ -> `mem_rd`=0 immediately; `MonDReg`=0; `monitor_ready`=1; `mem_addr`=0.
